ps2_key_decoder: RTL and testbench

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_pkg.sv | 48 ++++
 rtl/ps2_key_decoder_if.sv | 14 +
 rtl/ps2_key_decoder_core.sv | 135 +++++++++++++
 rtl/ps2_sync_edge.sv | 26 ++
 rtl/ps2_key_decoder.sv | 52 +++++
 tb/tb_ps2_key_decoder.sv | 226 ++++++++++++++++++++++
 6 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 decoder types and constants: FSM states, scancodes, held-key bits, watchdog.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  localparam logic [7:0] PFX_EXT  = 8'hE0;
  localparam logic [7:0] PFX_BRK  = 8'hF0;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;

  localparam int HELD_W     = 5;
  localparam int HELD_UP    = 0;
  localparam int HELD_DOWN  = 1;
  localparam int HELD_LEFT  = 2;
  localparam int HELD_RIGHT = 3;
  localparam int HELD_SPACE = 4;

  localparam int WDOG_W = 13;
  localparam logic [WDOG_W-1:0] TIMEOUT_CYCLES = 13'd6000;

  // Arrows count only with the E0 prefix; space only without it.
  function automatic logic [HELD_W-1:0] held_mask(input logic [7:0] code, input logic ext);
    logic [HELD_W-1:0] m;
    m = '0;
    if (ext) begin
      case (code)
        SC_UP:    m[HELD_UP]    = 1'b1;
        SC_DOWN:  m[HELD_DOWN]  = 1'b1;
        SC_LEFT:  m[HELD_LEFT]  = 1'b1;
        SC_RIGHT: m[HELD_RIGHT] = 1'b1;
        default:  m = '0;
      endcase
    end else if (code == SC_SPACE) begin
      m[HELD_SPACE] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Decoded key-event bus: the decoder drives it (master), a consumer samples it (slave).
interface ps2_key_decoder_if;
  import ps2_pkg::*;

  logic [7:0]        key_code;
  logic              key_vld;
  logic              key_ext;
  logic              key_release;
  logic [HELD_W-1:0] keys_held;
  logic              frame_err;

  modport master (output key_code, key_vld, key_ext, key_release, keys_held, frame_err);
  modport slave  (input  key_code, key_vld, key_ext, key_release, keys_held, frame_err);
endinterface

// File: rtl/ps2_key_decoder_core.sv
// Frame FSM, prefix tracking, held-key flags and watchdog; all outputs registered,
// so events and errors appear the cycle after the stop-bit edge is seen.
module ps2_key_decoder_core
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_fall,
  input  logic ps2_dat,
  ps2_key_decoder_if.master evt
);
  ps2_state_e        state_q, state_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              par_ok_q, par_ok_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              ext_q, ext_d, brk_q, brk_d;
  logic [7:0]        code_q, code_d;
  logic              kext_q, kext_d, krel_q, krel_d;
  logic              vld_q, vld_d, err_q, err_d;
  logic [HELD_W-1:0] held_q, held_d, mask;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    par_ok_d = par_ok_q;
    wdog_d   = wdog_q;
    ext_d    = ext_q;
    brk_d    = brk_q;
    code_d   = code_q;
    kext_d   = kext_q;
    krel_d   = krel_q;
    vld_d    = 1'b0;
    err_d    = 1'b0;
    held_d   = held_q;
    mask     = held_mask(shift_q, ext_q);

    // An edge always wins over a simultaneous watchdog expiry.
    if (ps2_fall) begin
      wdog_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (!ps2_dat) begin
            state_d = ST_DATA;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        ST_DATA: begin
          shift_d = {ps2_dat, shift_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_ok_d = ^{shift_q, ps2_dat};
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (ps2_dat && par_ok_q) begin
            if (shift_q == PFX_EXT) begin
              ext_d = 1'b1;
            end else if (shift_q == PFX_BRK) begin
              brk_d = 1'b1;
            end else begin
              code_d = shift_q;
              kext_d = ext_q;
              krel_d = brk_q;
              vld_d  = 1'b1;
              ext_d  = 1'b0;
              brk_d  = 1'b0;
              held_d = brk_q ? (held_q & ~mask) : (held_q | mask);
            end
          end else begin
            err_d = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (wdog_q == TIMEOUT_CYCLES - 13'd1) begin
        state_d = ST_IDLE;
        wdog_d  = '0;
        err_d   = 1'b1;
        ext_d   = 1'b0;
        brk_d   = 1'b0;
      end else begin
        wdog_d = wdog_q + 13'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      par_ok_q <= 1'b0;
      wdog_q   <= '0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      code_q   <= '0;
      kext_q   <= 1'b0;
      krel_q   <= 1'b0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
      held_q   <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      par_ok_q <= par_ok_d;
      wdog_q   <= wdog_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      code_q   <= code_d;
      kext_q   <= kext_d;
      krel_q   <= krel_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
      held_q   <= held_d;
    end
  end

  assign evt.key_code    = code_q;
  assign evt.key_vld     = vld_q;
  assign evt.key_ext     = kext_q;
  assign evt.key_release = krel_q;
  assign evt.keys_held   = held_q;
  assign evt.frame_err   = err_q;
endmodule

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer with falling-edge detect; flops preset to 1 (idle bus) so reset
// release cannot look like an edge. fall is a one-cycle pulse, two cycles after the input drops.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic fall
);
  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_out = sync_q;
  assign fall     = prev_q & ~sync_q;
endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder top: synchronizes the raw lines and exposes decoded key events.
// KEY_VALID / FRAME_ERR pulse one cycle after the stop-bit edge; no backpressure (fire and forget).
module ps2_key_decoder
  import ps2_pkg::*;
(
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic              PS2_CLK,
  input  logic              PS2_DAT,
  output logic [7:0]        KEY_CODE,
  output logic              KEY_VALID,
  output logic              KEY_EXT,
  output logic              KEY_RELEASE,
  output logic [HELD_W-1:0] KEYS_HELD,
  output logic              FRAME_ERR
);
  logic ps2_clk_fall, ps2_clk_sync_unused;
  logic ps2_dat_sync, ps2_dat_fall_unused;

  ps2_sync_edge u_clk_sync (
    .clk      (CLOCK_50),
    .rst_n    (RESET),
    .async_in (PS2_CLK),
    .sync_out (ps2_clk_sync_unused),
    .fall     (ps2_clk_fall)
  );

  ps2_sync_edge u_dat_sync (
    .clk      (CLOCK_50),
    .rst_n    (RESET),
    .async_in (PS2_DAT),
    .sync_out (ps2_dat_sync),
    .fall     (ps2_dat_fall_unused)
  );

  ps2_key_decoder_if evt_if ();

  ps2_key_decoder_core u_core (
    .clk      (CLOCK_50),
    .rst_n    (RESET),
    .ps2_fall (ps2_clk_fall),
    .ps2_dat  (ps2_dat_sync),
    .evt      (evt_if.master)
  );

  assign KEY_CODE    = evt_if.key_code;
  assign KEY_VALID   = evt_if.key_vld;
  assign KEY_EXT     = evt_if.key_ext;
  assign KEY_RELEASE = evt_if.key_release;
  assign KEYS_HELD   = evt_if.keys_held;
  assign FRAME_ERR   = evt_if.frame_err;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-banged PS/2 frames with hand-computed expectations.
module tb_ps2_key_decoder;
  logic       CLOCK_50;
  logic       RESET;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [7:0] KEY_CODE;
  logic       KEY_VALID;
  logic       KEY_EXT;
  logic       KEY_RELEASE;
  logic [4:0] KEYS_HELD;
  logic       FRAME_ERR;

  ps2_key_decoder_if obs ();

  ps2_key_decoder dut (
    .CLOCK_50    (CLOCK_50),
    .RESET       (RESET),
    .PS2_CLK     (PS2_CLK),
    .PS2_DAT     (PS2_DAT),
    .KEY_CODE    (KEY_CODE),
    .KEY_VALID   (KEY_VALID),
    .KEY_EXT     (KEY_EXT),
    .KEY_RELEASE (KEY_RELEASE),
    .KEYS_HELD   (KEYS_HELD),
    .FRAME_ERR   (FRAME_ERR)
  );

  assign obs.key_code    = KEY_CODE;
  assign obs.key_vld     = KEY_VALID;
  assign obs.key_ext     = KEY_EXT;
  assign obs.key_release = KEY_RELEASE;
  assign obs.keys_held   = KEYS_HELD;
  assign obs.frame_err   = FRAME_ERR;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int vld_cnt  = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  int err_cyc  = 0;
  int last_fall_cyc = 0;
  int ev_lat   = 0;
  int v0, e0;

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  always @(negedge CLOCK_50) begin
    if (obs.key_vld) vld_cnt <= vld_cnt + 1;
    if (obs.frame_err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (obs.key_vld && obs.frame_err) both_cnt <= both_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, observed cycle %0d required < 100000", cyc);
    $fatal(1, "bench time limit");
  end

  task automatic check(input string tag, input int observed, input int expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // bits[0] goes first; ev_lat records the first cycle an event/error shows during the 11th bit.
  task automatic send_bits(input logic [10:0] bits, input int n);
    ev_lat = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLOCK_50);
      PS2_DAT = bits[i];
      idle(10);
      PS2_CLK = 1'b0;
      last_fall_cyc = cyc;
      for (int k = 1; k <= 20; k++) begin
        @(negedge CLOCK_50);
        if (i == 10 && ev_lat == 0 && (obs.key_vld || obs.frame_err)) ev_lat = k;
      end
      PS2_CLK = 1'b1;
      idle(10);
    end
    PS2_DAT = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic flip_par, input logic stop);
    logic par;
    par = ~(^code) ^ flip_par;
    send_bits({stop, par, code, 1'b0}, 11);
    idle(20);
  endtask

  initial begin
    RESET   = 1'b1;
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    #5 RESET = 1'b0;
    idle(5);
    check("rst_code",    int'(obs.key_code),    0);
    check("rst_valid",   int'(obs.key_vld),     0);
    check("rst_ext",     int'(obs.key_ext),     0);
    check("rst_release", int'(obs.key_release), 0);
    check("rst_held",    int'(obs.keys_held),   0);
    check("rst_err",     int'(obs.frame_err),   0);
    RESET = 1'b1;
    idle(20);
    check("rel_no_event", vld_cnt + err_cnt, 0);

    // Space make
    v0 = vld_cnt; e0 = err_cnt;
    send_frame(8'h29, 1'b0, 1'b1);
    check("sp_latency", ev_lat, 3);
    check("sp_vld_cnt", vld_cnt - v0, 1);
    check("sp_err_cnt", err_cnt - e0, 0);
    check("sp_code",    int'(obs.key_code), 'h29);
    check("sp_ext",     int'(obs.key_ext), 0);
    check("sp_rel",     int'(obs.key_release), 0);
    check("sp_held",    int'(obs.keys_held), 'b10000);

    // Up arrow make then break
    v0 = vld_cnt;
    send_frame(8'hE0, 1'b0, 1'b1);
    check("up_pfx_nopulse", vld_cnt - v0, 0);
    send_frame(8'h75, 1'b0, 1'b1);
    check("up_mk_vld",  vld_cnt - v0, 1);
    check("up_mk_ext",  int'(obs.key_ext), 1);
    check("up_mk_rel",  int'(obs.key_release), 0);
    check("up_mk_held", int'(obs.keys_held), 'b10001);
    v0 = vld_cnt;
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    check("up_brk_pfx_nopulse", vld_cnt - v0, 0);
    send_frame(8'h75, 1'b0, 1'b1);
    check("up_brk_vld",  vld_cnt - v0, 1);
    check("up_brk_code", int'(obs.key_code), 'h75);
    check("up_brk_ext",  int'(obs.key_ext), 1);
    check("up_brk_rel",  int'(obs.key_release), 1);
    check("up_brk_held", int'(obs.keys_held), 'b10000);

    // Parity error, then the same code received cleanly
    v0 = vld_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
    check("par_latency", ev_lat, 3);
    check("par_err_cnt", err_cnt - e0, 1);
    check("par_vld_cnt", vld_cnt - v0, 0);
    check("par_code_kept", int'(obs.key_code), 'h75);
    send_frame(8'h1C, 1'b0, 1'b1);
    check("a_vld_cnt", vld_cnt - v0, 1);
    check("a_code", int'(obs.key_code), 'h1C);
    check("a_ext",  int'(obs.key_ext), 0);
    check("a_rel",  int'(obs.key_release), 0);

    // Truncated frame (start + 4 data bits) then a long idle gap
    e0 = err_cnt; v0 = vld_cnt;
    send_bits({1'b1, 1'b1, 8'h5A, 1'b0}, 5);
    idle(7000);
    check("wd_err_cnt", err_cnt - e0, 1);
    check("wd_vld_cnt", vld_cnt - v0, 0);
    check("wd_delay_window", int'((err_cyc - last_fall_cyc) >= 6000 && (err_cyc - last_fall_cyc) <= 6006), 1);
    send_frame(8'h74, 1'b0, 1'b1);
    check("wd_next_vld",  vld_cnt - v0, 1);
    check("wd_next_code", int'(obs.key_code), 'h74);
    check("wd_next_ext",  int'(obs.key_ext), 0);
    check("wd_next_held", int'(obs.keys_held), 'b10000);

    // Typematic repeat of held space
    v0 = vld_cnt;
    send_frame(8'h29, 1'b0, 1'b1);
    check("rep_vld",  vld_cnt - v0, 1);
    check("rep_held", int'(obs.keys_held), 'b10000);

    // Bad stop bit
    v0 = vld_cnt; e0 = err_cnt;
    send_frame(8'h29, 1'b0, 1'b0);
    check("stop_err_cnt", err_cnt - e0, 1);
    check("stop_vld_cnt", vld_cnt - v0, 0);
    check("stop_held",    int'(obs.keys_held), 'b10000);

    // Reset in the middle of a frame that follows an E0 prefix
    send_frame(8'hE0, 1'b0, 1'b1);
    send_bits({1'b1, 1'b0, 8'h6B, 1'b0}, 6);
    @(negedge CLOCK_50);
    RESET = 1'b0;
    #2;
    check("mid_rst_code", int'(obs.key_code),    0);
    check("mid_rst_ext",  int'(obs.key_ext),     0);
    check("mid_rst_rel",  int'(obs.key_release), 0);
    check("mid_rst_held", int'(obs.keys_held),   0);
    check("mid_rst_vld",  int'(obs.key_vld),     0);
    check("mid_rst_err",  int'(obs.frame_err),   0);
    idle(5);
    RESET = 1'b1;
    v0 = vld_cnt; e0 = err_cnt;
    idle(50);
    check("post_rst_quiet", (vld_cnt - v0) + (err_cnt - e0), 0);
    send_frame(8'h6B, 1'b0, 1'b1);
    check("lf_mk_vld",  vld_cnt - v0, 1);
    check("lf_mk_code", int'(obs.key_code), 'h6B);
    check("lf_mk_ext",  int'(obs.key_ext), 0);
    check("lf_mk_held", int'(obs.keys_held), 0);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h6B, 1'b0, 1'b1);
    check("lf_brk_vld",  vld_cnt - v0, 2);
    check("lf_brk_ext",  int'(obs.key_ext), 0);
    check("lf_brk_rel",  int'(obs.key_release), 1);
    check("lf_brk_held", int'(obs.keys_held), 0);
    check("lf_err_cnt",  err_cnt - e0, 0);

    check("vld_err_overlap", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
